// File: rtl/display_output_controller.sv
// Output-port register block: LED register, 16-bit hex display value and enable,
// driving a 4-digit multiplexed active-low 7-segment display.
module display_output_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] led,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [15:0]      disp;
  logic             en;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       nibble;
  logic             cnt_wrap;

  // Active-high gfedcba hex glyphs; inverted at the output register.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    nibble = disp[3:0];
    case (idx)
      2'd0: nibble = disp[3:0];
      2'd1: nibble = disp[7:4];
      2'd2: nibble = disp[11:8];
      default: nibble = disp[15:12];
    endcase
  end

  assign cnt_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign dp       = 1'b1;

  // Write handshake: every edge with we=1 is accepted immediately (no stall),
  // and ack is high for exactly the cycle following each accepted write edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      led  <= 8'h00;
      disp <= 16'h0000;
      en   <= 1'b1;
      cnt  <= '0;
      idx  <= 2'd0;
      ack  <= 1'b0;
      an   <= 4'b1111;
      seg  <= 7'h7F;
    end else begin
      ack <= we;
      if (we) begin
        case (addr)
          2'd0: disp[7:0]  <= wdata;
          2'd1: disp[15:8] <= wdata;
          2'd2: led        <= wdata;
          default: en      <= wdata[0];
        endcase
      end

      // Scan runs even while blanked, so re-enabling resumes mid-scan.
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (en) begin
        an  <= ~(4'b0001 << idx);
        seg <= ~hex7(nibble);
      end else begin
        an  <= 4'b1111;
        seg <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_display_output_controller.sv
// Directed bench for display_output_controller with REFRESH_DIV=4: scan order,
// register writes, ack timing, blanking, write/advance collision and reset.
module tb_display_output_controller;

  logic       clk;
  logic       reset;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] led;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: edges since reset release and the written registers.
  int          n      = 0;
  logic [15:0] m_disp = 16'h0000;
  logic        m_en   = 1'b1;
  logic [7:0]  m_led  = 8'h00;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  display_output_controller #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .led   (led),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge: predict outputs from pre-edge state, advance the model, compare.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ack;
    int         di;
    di = (n / 4) % 4;
    if (reset || !m_en) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
    end else begin
      e_an  = ~(4'b0001 << di);
      e_seg = ~hex_tab[m_disp[di*4 +: 4]];
    end
    e_ack = we && !reset;
    if (reset) begin
      n = 0; m_disp = 16'h0000; m_en = 1'b1; m_led = 8'h00;
    end else begin
      n++;
      if (we) begin
        case (addr)
          2'd0: m_disp[7:0]  = wdata;
          2'd1: m_disp[15:8] = wdata;
          2'd2: m_led        = wdata;
          default: m_en      = wdata[0];
        endcase
      end
    end
    @(posedge clk);
    #1;
    check("an",  {4'h0, an},  {4'h0, e_an});
    check("seg", {1'b0, seg}, {1'b0, e_seg});
    check("ack", {7'h0, ack}, {7'h0, e_ack});
    check("led", led, m_led);
    check("dp",  {7'h0, dp},  8'h01);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    #1;
    repeat (3) step();
    check("reset_an",  {4'h0, an}, 8'h0F);
    check("reset_seg", {1'b0, seg}, 8'h7F);
    check("reset_led", led, 8'h00);

    // Free-running scan of zeros, each digit held 4 cycles.
    reset = 1'b0;
    step();
    check("first_an",  {4'h0, an}, 8'h0E);
    check("first_seg", {1'b0, seg}, 8'h40);
    repeat (19) step();

    // Two back-to-back display writes: disp = 5C3A.
    we = 1'b1; addr = 2'd0; wdata = 8'h3A;
    step();
    check("ack_w0", {7'h0, ack}, 8'h01);
    addr = 2'd1; wdata = 8'h5C;
    step();
    check("ack_w1", {7'h0, ack}, 8'h01);
    we = 1'b0;
    step();
    check("ack_idle", {7'h0, ack}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      case (an)
        4'b1110: check("dig0_A", {1'b0, seg}, 8'h08);
        4'b1101: check("dig1_3", {1'b0, seg}, 8'h30);
        4'b1011: check("dig2_C", {1'b0, seg}, 8'h46);
        4'b0111: check("dig3_5", {1'b0, seg}, 8'h12);
        default: check("an_onehot", {4'h0, an}, 8'h0E);
      endcase
    end

    // LED write.
    we = 1'b1; addr = 2'd2; wdata = 8'hA5;
    step();
    we = 1'b0;
    check("led_a5", led, 8'hA5);
    repeat (3) step();

    // High-byte write on the edge where cnt==3 and idx==2.
    for (int i = 0; i < 16 && (n % 16) != 11; i++) step();
    we = 1'b1; addr = 2'd1; wdata = 8'h7C;
    step();
    we = 1'b0;
    step();
    check("collide_an",  {4'h0, an}, 8'h07);
    check("collide_seg", {1'b0, seg}, 8'h78);

    // Blank, wait, then re-enable mid-scan.
    we = 1'b1; addr = 2'd3; wdata = 8'h00;
    step();
    we = 1'b0;
    step();
    check("blank_an",  {4'h0, an}, 8'h0F);
    check("blank_seg", {1'b0, seg}, 8'h7F);
    repeat (5) step();
    we = 1'b1; addr = 2'd3; wdata = 8'hFF;
    step();
    we = 1'b0;
    repeat (6) step();

    // Reset during a write: write dropped, scan restarts at digit 0.
    reset = 1'b1; we = 1'b1; addr = 2'd2; wdata = 8'hFF;
    step();
    check("rst_led", led, 8'h00);
    check("rst_ack", {7'h0, ack}, 8'h00);
    reset = 1'b0; we = 1'b0;
    step();
    check("restart_an",  {4'h0, an}, 8'h0E);
    check("restart_seg", {1'b0, seg}, 8'h40);
    check("restart_led", led, 8'h00);
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
